// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: fetch/decode/execute/memory/write-back sequencing.
// Optional macro ILLEGAL_TRAP_EN: unknown opcodes park the FSM in TRAP instead of retiring as NOP.
module rv_multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [31:0] inst,
  input  logic        alu_zero,
  input  logic        alu_neg,
  input  logic        mem_ready,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        reg_we,
  output logic        mem_req,
  output logic        mem_we,
  output logic [2:0]  imm_op,
  output logic [2:0]  alu_op,
  output logic        alu_src_b,
  output logic [1:0]  wb_sel,
  output logic        retire,
  output logic        err,
  output logic [2:0]  state_o
);
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  state_t      state, state_n;
  logic [31:0] ir;
  logic [7:0]  wait_cnt, wait_cnt_n;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_r, is_i, is_load, is_store, is_branch, is_lui, is_jal, is_jalr, is_known;
  logic       br_taken, mem_timeout, in_decode;
  logic       unused_ir;

  assign opcode    = ir[6:0];
  assign funct3    = ir[14:12];
  assign unused_ir = ^{ir[31], ir[29:15], ir[11:7]};

  assign is_r      = (opcode == OP_R);
  assign is_i      = (opcode == OP_I);
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_lui    = (opcode == OP_LUI);
  assign is_jal    = (opcode == OP_JAL);
  assign is_jalr   = (opcode == OP_JALR);
  assign is_known  = is_r | is_i | is_load | is_store | is_branch | is_lui | is_jal | is_jalr;

  // Unsupported branch funct3 codes fall through as not-taken.
  always_comb begin
    case (funct3)
      3'b000:  br_taken = alu_zero;
      3'b001:  br_taken = !alu_zero;
      3'b100:  br_taken = alu_neg;
      3'b101:  br_taken = !alu_neg;
      default: br_taken = 1'b0;
    endcase
  end

  // Memory handshake: mem_req stays high in MEM until a cycle with mem_ready=1
  // completes the access; err fires on the MEM_TIMEOUT-th consecutive wait cycle.
  assign mem_timeout = (wait_cnt == 8'(MEM_TIMEOUT - 1)) && !mem_ready;
  assign wait_cnt_n  = (state == S_MEM && !mem_ready && !mem_timeout) ? wait_cnt + 8'd1 : 8'd0;
  assign in_decode   = (state == S_DECODE) || (state == S_EXEC) || (state == S_MEM) || (state == S_WB);
  assign state_o     = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_FETCH;
      ir       <= 32'd0;
      wait_cnt <= 8'd0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_cnt_n;
      if (ir_we) ir <= inst;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_FETCH:  if (run) state_n = S_DECODE;
      S_DECODE: state_n = S_EXEC;
      S_EXEC: begin
        if (is_branch)                state_n = S_FETCH;
        else if (is_load || is_store) state_n = S_MEM;
        else if (is_known)            state_n = S_WB;
        else begin
`ifdef ILLEGAL_TRAP_EN
          state_n = S_TRAP;
`else
          state_n = S_FETCH;
`endif
        end
      end
      S_MEM: begin
        if (mem_ready)        state_n = is_store ? S_FETCH : S_WB;
        else if (mem_timeout) state_n = S_FETCH;
      end
      S_WB:     state_n = S_FETCH;
      S_TRAP:   state_n = S_TRAP;
      default:  state_n = S_FETCH;
    endcase
  end

  always_comb begin
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = 2'd0;
    reg_we    = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    imm_op    = 3'd0;
    alu_op    = 3'd0;
    alu_src_b = 1'b0;
    wb_sel    = 2'd0;
    retire    = 1'b0;
    err       = 1'b0;

    // Datapath selects follow the IR from DECODE through WB.
    if (in_decode) begin
      if (is_store)       imm_op = 3'd1;
      else if (is_branch) imm_op = 3'd2;
      else if (is_jal)    imm_op = 3'd3;
      else if (is_lui)    imm_op = 3'd4;
      alu_src_b = is_i | is_load | is_store | is_jalr;
      if (is_branch) alu_op = 3'd1;
      else if (is_r || is_i) begin
        case (funct3)
          3'b000:  alu_op = (is_r && ir[30]) ? 3'd1 : 3'd0;
          3'b111:  alu_op = 3'd2;
          3'b110:  alu_op = 3'd3;
          3'b100:  alu_op = 3'd4;
          3'b010:  alu_op = 3'd5;
          default: alu_op = 3'd0;
        endcase
      end
    end

    case (state)
      S_FETCH: ir_we = run;
      S_EXEC: begin
        if (is_branch) begin
          pc_we  = 1'b1;
          pc_src = br_taken ? 2'd1 : 2'd0;
          retire = 1'b1;
        end else if (!is_known) begin
`ifndef ILLEGAL_TRAP_EN
          pc_we  = 1'b1;
          retire = 1'b1;
`endif
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = is_store;
        err     = mem_timeout;
        if (mem_ready && is_store) begin
          pc_we  = 1'b1;
          retire = 1'b1;
        end
      end
      S_WB: begin
        reg_we = 1'b1;
        pc_we  = 1'b1;
        retire = 1'b1;
        if (is_load)                wb_sel = 2'd1;
        else if (is_lui)            wb_sel = 2'd3;
        else if (is_jal || is_jalr) wb_sel = 2'd2;
        if (is_jal)       pc_src = 2'd1;
        else if (is_jalr) pc_src = 2'd2;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Directed bench for rv_multicycle_ctrl: per-cycle control traces checked against hand-derived values.
module tb_rv_multicycle_ctrl;
  logic        clk = 1'b0;
  logic        rst, run, alu_zero, alu_neg, mem_ready;
  logic [31:0] inst;
  logic        ir_we, pc_we, reg_we, mem_req, mem_we, alu_src_b, retire, err;
  logic [1:0]  pc_src, wb_sel;
  logic [2:0]  imm_op, alu_op, state_o;

  int total = 0;
  int bad   = 0;
  int n_cyc;
  logic [7:0] exp_q[$];

  // Per-cycle trace of one instruction; en = {ir_we,pc_we,reg_we,mem_req,mem_we,retire,err}
  logic [6:0] tr_en [64];
  logic [2:0] tr_st [64];
  logic [1:0] tr_pcs[64];
  logic [1:0] tr_wb [64];
  logic [2:0] tr_alu[64];
  logic [2:0] tr_imm[64];
  logic       tr_src[64];

  rv_multicycle_ctrl #(.MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .run(run), .inst(inst), .alu_zero(alu_zero), .alu_neg(alu_neg),
    .mem_ready(mem_ready), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we),
    .mem_req(mem_req), .mem_we(mem_we), .imm_op(imm_op), .alu_op(alu_op), .alu_src_b(alu_src_b),
    .wb_sel(wb_sel), .retire(retire), .err(err), .state_o(state_o)
  );

  // clock
  always #5 clk = ~clk;

  function automatic logic [6:0] en_now();
    return {ir_we, pc_we, reg_we, mem_req, mem_we, retire, err};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Issue one instruction from FETCH; waits<0 keeps mem_ready low forever in MEM.
  // mem_ready is driven high outside MEM, where it must be ignored.
  task automatic issue(input logic [31:0] ins, input int waits, input logic zero,
                       input logic neg, input int max_cyc);
    int  mem_cyc;
    bit  done;
    mem_cyc = 0;
    done    = 1'b0;
    n_cyc   = 0;
    inst = ins; alu_zero = zero; alu_neg = neg; run = 1'b1;
    while (!done && n_cyc < max_cyc) begin
      if (state_o == 3'd3) mem_ready = (waits >= 0) && (mem_cyc >= waits);
      else                 mem_ready = 1'b1;
      #1;
      tr_en[n_cyc]  = en_now();
      tr_st[n_cyc]  = state_o;
      tr_pcs[n_cyc] = pc_src;
      tr_wb[n_cyc]  = wb_sel;
      tr_alu[n_cyc] = alu_op;
      tr_imm[n_cyc] = imm_op;
      tr_src[n_cyc] = alu_src_b;
      if (state_o == 3'd3) mem_cyc++;
      if (retire || err) done = 1'b1;
      n_cyc++;
      @(posedge clk); #1;
    end
    run = 1'b0;
    mem_ready = 1'b0;
  endtask

  task automatic run_one(input string tag, input logic [31:0] ins, input int waits,
                         input logic zero, input logic neg, input int max_cyc, input logic [7:0] lat);
    exp_q.push_back(lat);
    issue(ins, waits, zero, neg, max_cyc);
    chk({tag, "_lat"}, 32'(n_cyc), 32'(exp_q.pop_front()));
  endtask

  initial begin
    logic any_pc;
    int   n_req;
    rst = 1'b0; run = 1'b0; inst = 32'd0; alu_zero = 1'b0; alu_neg = 1'b0; mem_ready = 1'b0;
    #3;
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_en", 32'(en_now()), 32'd0);
    chk("rst_sel", 32'({pc_src, imm_op, alu_op, alu_src_b, wb_sel}), 32'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("idle_state", 32'(state_o), 32'd0);
      chk("idle_en", 32'(en_now()), 32'd0);
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;

    // add x3,x1,x2
    run_one("add", 32'h002081B3, 0, 1'b0, 1'b0, 12, 8'd4);
    chk("add_c1", 32'(tr_en[0]), 32'b1000000);
    chk("add_dec_st", 32'(tr_st[1]), 32'd1);
    chk("add_dec_en", 32'(tr_en[1]), 32'd0);
    chk("add_ex_en", 32'(tr_en[2]), 32'd0);
    chk("add_ex_src", 32'(tr_src[2]), 32'd0);
    chk("add_wb_st", 32'(tr_st[3]), 32'd4);
    chk("add_wb_en", 32'(tr_en[3]), 32'b0110010);
    chk("add_wb_sel", 32'(tr_wb[3]), 32'd0);
    chk("add_wb_alu", 32'(tr_alu[3]), 32'd0);
    chk("add_wb_pcs", 32'(tr_pcs[3]), 32'd0);

    // sub x2,x1,x2 ; xori x1,x2,5 ; addi with imm[10]=1 must not become SUB
    run_one("sub", 32'h40208133, 0, 1'b0, 1'b0, 12, 8'd4);
    chk("sub_alu", 32'(tr_alu[2]), 32'd1);
    run_one("xori", 32'h00514093, 0, 1'b0, 1'b0, 12, 8'd4);
    chk("xori_alu", 32'(tr_alu[2]), 32'd4);
    chk("xori_src", 32'(tr_src[2]), 32'd1);
    run_one("addi_hi", 32'h40000093, 0, 1'b0, 1'b0, 12, 8'd4);
    chk("addi_hi_alu", 32'(tr_alu[2]), 32'd0);

    // branches: beq taken / not taken, bne taken, blt taken, bge not taken
    run_one("beq_t", 32'h00208463, 0, 1'b1, 1'b0, 12, 8'd3);
    chk("beq_t_en", 32'(tr_en[2]), 32'b0100010);
    chk("beq_t_pcs", 32'(tr_pcs[2]), 32'd1);
    chk("beq_t_alu", 32'(tr_alu[2]), 32'd1);
    chk("beq_t_src", 32'(tr_src[2]), 32'd0);
    chk("beq_imm", 32'(tr_imm[1]), 32'd2);
    run_one("beq_n", 32'h00208463, 0, 1'b0, 1'b0, 12, 8'd3);
    chk("beq_n_en", 32'(tr_en[2]), 32'b0100010);
    chk("beq_n_pcs", 32'(tr_pcs[2]), 32'd0);
    run_one("bne_t", 32'h00209463, 0, 1'b0, 1'b0, 12, 8'd3);
    chk("bne_t_pcs", 32'(tr_pcs[2]), 32'd1);
    run_one("blt_t", 32'h0020C463, 0, 1'b0, 1'b1, 12, 8'd3);
    chk("blt_t_pcs", 32'(tr_pcs[2]), 32'd1);
    run_one("bge_n", 32'h0020D463, 0, 1'b0, 1'b1, 12, 8'd3);
    chk("bge_n_pcs", 32'(tr_pcs[2]), 32'd0);

    // lw x5,4(x1) with 3 wait cycles
    run_one("lw", 32'h0040A283, 3, 1'b0, 1'b0, 20, 8'd8);
    n_req = 0;
    for (int i = 0; i < 8; i++) if (tr_en[i][3]) n_req++;
    chk("lw_req_cyc", 32'(n_req), 32'd4);
    chk("lw_mem_en", 32'(tr_en[5]), 32'b0001000);
    chk("lw_ex_src", 32'(tr_src[2]), 32'd1);
    chk("lw_ex_alu", 32'(tr_alu[2]), 32'd0);
    chk("lw_imm", 32'(tr_imm[1]), 32'd0);
    chk("lw_wb_en", 32'(tr_en[7]), 32'b0110010);
    chk("lw_wb_sel", 32'(tr_wb[7]), 32'd1);

    // sw x2,8(x1) immediate completion, then timeout
    run_one("sw", 32'h0020A423, 0, 1'b0, 1'b0, 12, 8'd4);
    chk("sw_mem_en", 32'(tr_en[3]), 32'b0101110);
    chk("sw_imm", 32'(tr_imm[1]), 32'd1);
    run_one("sw_to", 32'h0020A423, -1, 1'b0, 1'b0, 40, 8'd19);
    chk("sw_to_pre", 32'(tr_en[17]), 32'b0001100);
    chk("sw_to_err", 32'(tr_en[18]), 32'b0001101);
    any_pc = 1'b0;
    for (int i = 0; i < 19; i++) any_pc = any_pc | tr_en[i][5] | tr_en[i][1];
    chk("sw_to_nopc", 32'(any_pc), 32'd0);
    #1;
    chk("sw_to_state", 32'(state_o), 32'd0);

    // jalr / jal / lui write-back selects
    run_one("jalr", 32'h000280E7, 0, 1'b0, 1'b0, 12, 8'd4);
    chk("jalr_en", 32'(tr_en[3]), 32'b0110010);
    chk("jalr_wb", 32'(tr_wb[3]), 32'd2);
    chk("jalr_pcs", 32'(tr_pcs[3]), 32'd2);
    chk("jalr_alu", 32'(tr_alu[3]), 32'd0);
    chk("jalr_src", 32'(tr_src[3]), 32'd1);
    run_one("jal", 32'h010000EF, 0, 1'b0, 1'b0, 12, 8'd4);
    chk("jal_wb", 32'(tr_wb[3]), 32'd2);
    chk("jal_pcs", 32'(tr_pcs[3]), 32'd1);
    chk("jal_imm", 32'(tr_imm[1]), 32'd3);
    run_one("lui", 32'h123450B7, 0, 1'b0, 1'b0, 12, 8'd4);
    chk("lui_wb", 32'(tr_wb[3]), 32'd3);
    chk("lui_pcs", 32'(tr_pcs[3]), 32'd0);
    chk("lui_imm", 32'(tr_imm[1]), 32'd4);

    // reset asserted while a store waits in MEM
    inst = 32'h0020A423; run = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
    run = 1'b0;
    #1;
    chk("mid_mem_state", 32'(state_o), 32'd3);
    chk("mid_mem_req", 32'(mem_req), 32'd1);
    rst = 1'b0;
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_state", 32'(state_o), 32'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // unknown opcode 0x7F
`ifdef ILLEGAL_TRAP_EN
    run_one("ill", 32'h0000007F, 0, 1'b0, 1'b0, 8, 8'd8);
    chk("ill_trap_st", 32'(tr_st[3]), 32'd5);
    chk("ill_trap_hold", 32'(tr_st[7]), 32'd5);
    chk("ill_trap_en", 32'(tr_en[7]), 32'd0);
    any_pc = 1'b0;
    for (int i = 0; i < 8; i++) any_pc = any_pc | tr_en[i][5];
    chk("ill_nopc", 32'(any_pc), 32'd0);
`else
    run_one("ill", 32'h0000007F, 0, 1'b0, 1'b0, 12, 8'd3);
    chk("ill_nop_en", 32'(tr_en[2]), 32'b0100010);
    chk("ill_nop_pcs", 32'(tr_pcs[2]), 32'd0);
    #1;
    chk("ill_nop_state", 32'(state_o), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
